// File: rtl/drum_pipe_if.sv
// drum_pipe_if: operand/result bus for the drum_pipe approximate multiplier.
//   in_*      : operand pair, mode bits and tag offered by the source (valid/ready)
//   out_*     : product, tag and truncation flag offered to the sink (valid/ready)
//   op_count  : saturating count of completed result handshakes
// Modports: master = source/sink side, slave = the multiplier.
interface drum_pipe_if #(
    parameter int N     = 16,
    parameter int M     = 16,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [M-1:0]     in_b;
    logic             in_signed;
    logic             in_exact;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [N+M-1:0]   out_r;
    logic [TAG_W-1:0] out_tag;
    logic             out_trunc;
    logic [15:0]      op_count;

    modport master (
        output in_valid, in_a, in_b, in_signed, in_exact, in_tag, out_ready,
        input  in_ready, out_valid, out_r, out_tag, out_trunc, op_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, in_exact, in_tag, out_ready,
        output in_ready, out_valid, out_r, out_tag, out_trunc, op_count
    );
endinterface

// File: rtl/drum_pipe.sv
// drum_pipe: three-stage pipelined DRUM-K approximate / exact multiplier.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, flushes every in-flight operation
//   bus  : drum_pipe_if.slave -- operand handshake in, result handshake out,
//          saturating op_count of completed results
// Stages: S1 conditioning + leading-one detect, S2 multiply, S3 shift/sign.
// All stages advance together whenever the output register is empty or drained.
module drum_pipe #(
    parameter int N     = 16,
    parameter int M     = 16,
    parameter int K     = 6,
    parameter int TAG_W = 4
) (
    input logic        clk,
    input logic        rst,
    drum_pipe_if.slave bus
);
    localparam int MX  = (N > M) ? N : M;
    localparam int TW  = $clog2(MX);
    localparam int RW  = N + M;
    localparam int PKW = 2 * K;
    localparam logic [TW-1:0] KM1 = TW'(K - 1);

    // Index of the most significant set bit; zero input maps to index 0.
    function automatic logic [TW-1:0] lead_one(input logic [MX-1:0] v);
        logic [TW-1:0] idx;
        idx = '0;
        for (int i = 0; i < MX; i++) begin
            if (v[i]) begin
                idx = TW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Kept K-bit segment: top K-1 bits below-and-including the leading one,
    // with the dropped tail replaced by a forced 1 (DRUM unbiasing).
    function automatic logic [K-1:0] seg_of(input logic [MX-1:0] v, input logic [TW-1:0] t);
        logic [K-1:0] seg;
        if (t > KM1) begin
            seg = K'(v >> (t - KM1)) | {{(K-1){1'b0}}, 1'b1};
        end else begin
            seg = v[K-1:0];
        end
        return seg;
    endfunction

    // Left shift that restores the segment to its original weight.
    function automatic logic [TW-1:0] shift_of(input logic [TW-1:0] t);
        logic [TW-1:0] p;
        if (t > KM1) begin
            p = t - KM1;
        end else begin
            p = '0;
        end
        return p;
    endfunction

    logic                en_s;
    logic [MX-1:0]       mag_a_s;
    logic [MX-1:0]       mag_b_s;
    logic [TW-1:0]       lead_a_s;
    logic [TW-1:0]       lead_b_s;
    logic                sign_s;
    logic                trunc_s;

    // S1 registers
    logic                v1_r;
    logic [K-1:0]        seg_a_r;
    logic [K-1:0]        seg_b_r;
    logic [TW-1:0]       p_a_r;
    logic [TW-1:0]       p_b_r;
    logic                sign1_r;
    logic                exact1_r;
    logic                signed1_r;
    logic                trunc1_r;
    logic [TAG_W-1:0]    tag1_r;
    logic [N-1:0]        a1_r;
    logic [M-1:0]        b1_r;

    // S2 registers
    logic                v2_r;
    logic [PKW-1:0]      prod_k_r;
    logic [RW-1:0]       prod_x_r;
    logic [TW:0]         shift2_r;
    logic                sign2_r;
    logic                exact2_r;
    logic                trunc2_r;
    logic [TAG_W-1:0]    tag2_r;

    logic [RW-1:0]       a_ext_s;
    logic [RW-1:0]       b_ext_s;

    // S3 registers
    logic                v3_r;
    logic [RW-1:0]       out_r_r;
    logic [TAG_W-1:0]    out_tag_r;
    logic                out_trunc_r;
    logic [15:0]         op_count_r;

    logic [RW-1:0]       r_mag_s;
    logic [RW-1:0]       result_s;

    // Whole pipe moves only when the output slot is free or being drained.
    assign en_s = ~v3_r | bus.out_ready;

    // Operand conditioning: one's-complement magnitude in signed mode, then LOD.
    always_comb begin
        mag_a_s = '0;
        mag_b_s = '0;
        if (bus.in_signed && bus.in_a[N-1]) begin
            mag_a_s[N-1:0] = ~bus.in_a;
        end else begin
            mag_a_s[N-1:0] = bus.in_a;
        end
        if (bus.in_signed && bus.in_b[M-1]) begin
            mag_b_s[M-1:0] = ~bus.in_b;
        end else begin
            mag_b_s[M-1:0] = bus.in_b;
        end
        lead_a_s = lead_one(mag_a_s);
        lead_b_s = lead_one(mag_b_s);
        sign_s   = bus.in_signed & (bus.in_a[N-1] ^ bus.in_b[M-1]);
        trunc_s  = ~bus.in_exact & ((lead_a_s > KM1) | (lead_b_s > KM1));
    end

    // Stage 1: capture segments, shifts, sign, mode, tag and raw operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r      <= 1'b0;
            seg_a_r   <= '0;
            seg_b_r   <= '0;
            p_a_r     <= '0;
            p_b_r     <= '0;
            sign1_r   <= 1'b0;
            exact1_r  <= 1'b0;
            signed1_r <= 1'b0;
            trunc1_r  <= 1'b0;
            tag1_r    <= '0;
            a1_r      <= '0;
            b1_r      <= '0;
        end else if (en_s) begin
            v1_r      <= bus.in_valid;
            seg_a_r   <= seg_of(mag_a_s, lead_a_s);
            seg_b_r   <= seg_of(mag_b_s, lead_b_s);
            p_a_r     <= shift_of(lead_a_s);
            p_b_r     <= shift_of(lead_b_s);
            sign1_r   <= sign_s;
            exact1_r  <= bus.in_exact;
            signed1_r <= bus.in_signed;
            trunc1_r  <= trunc_s;
            tag1_r    <= bus.in_tag;
            a1_r      <= bus.in_a;
            b1_r      <= bus.in_b;
        end
    end

    // Exact operands widened to the full product width; a truncated product of
    // sign-extended values equals the two's-complement product.
    always_comb begin
        if (signed1_r) begin
            a_ext_s = {{M{a1_r[N-1]}}, a1_r};
            b_ext_s = {{N{b1_r[M-1]}}, b1_r};
        end else begin
            a_ext_s = {{M{1'b0}}, a1_r};
            b_ext_s = {{N{1'b0}}, b1_r};
        end
    end

    // Stage 2: K x K segment product and full exact product.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r     <= 1'b0;
            prod_k_r <= '0;
            prod_x_r <= '0;
            shift2_r <= '0;
            sign2_r  <= 1'b0;
            exact2_r <= 1'b0;
            trunc2_r <= 1'b0;
            tag2_r   <= '0;
        end else if (en_s) begin
            v2_r     <= v1_r;
            prod_k_r <= PKW'(seg_a_r) * PKW'(seg_b_r);
            prod_x_r <= a_ext_s * b_ext_s;
            shift2_r <= {1'b0, p_a_r} + {1'b0, p_b_r};
            sign2_r  <= sign1_r;
            exact2_r <= exact1_r;
            trunc2_r <= trunc1_r;
            tag2_r   <= tag1_r;
        end
    end

    // Approximate result: re-weight the segment product, then apply the sign.
    always_comb begin
        r_mag_s = RW'(prod_k_r) << shift2_r;
        if (exact2_r) begin
            result_s = prod_x_r;
        end else if (sign2_r) begin
            result_s = ~r_mag_s;
        end else begin
            result_s = r_mag_s;
        end
    end

    // Stage 3: output register, held while the sink stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_r        <= 1'b0;
            out_r_r     <= '0;
            out_tag_r   <= '0;
            out_trunc_r <= 1'b0;
        end else if (en_s) begin
            v3_r        <= v2_r;
            out_r_r     <= result_s;
            out_tag_r   <= tag2_r;
            out_trunc_r <= trunc2_r;
        end
    end

    // Saturating count of completed output handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_r <= 16'h0000;
        end else if (v3_r && bus.out_ready && (op_count_r != 16'hFFFF)) begin
            op_count_r <= op_count_r + 16'd1;
        end
    end

    // During reset the pipe reports ready although the input is discarded.
    assign bus.in_ready  = rst | en_s;
    assign bus.out_valid = v3_r;
    assign bus.out_r     = out_r_r;
    assign bus.out_tag   = out_tag_r;
    assign bus.out_trunc = out_trunc_r;
    assign bus.op_count  = op_count_r;

endmodule

// File: tb/tb_drum_pipe.sv
// tb_drum_pipe: directed and streaming checks of drum_pipe (N=M=16, K=6)
// with a queue scoreboard fed by a reference model.
module tb_drum_pipe;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   cyc;
    logic check_lat;

    typedef struct {
        logic [31:0] r;
        logic        trunc;
        logic [3:0]  tag;
        int          acc;
    } exp_t;

    exp_t scb[$];

    drum_pipe_if #(.N(16), .M(16), .TAG_W(4)) bus ();

    drum_pipe #(.N(16), .M(16), .K(6), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference DRUM-6 / exact multiply, returns {trunc, r}.
    function automatic logic [32:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic sg, input logic ex);
        longint      p;
        logic [63:0] full;
        logic [15:0] ma, mb;
        int          ta, tb, sa, sbb, sh;
        logic [31:0] mag, res;
        logic        s, tr;
        if (ex) begin
            if (sg) p = longint'($signed(a)) * longint'($signed(b));
            else    p = longint'(a) * longint'(b);
            full = p;
            return {1'b0, full[31:0]};
        end
        s  = sg & (a[15] ^ b[15]);
        ma = (sg && a[15]) ? ~a : a;
        mb = (sg && b[15]) ? ~b : b;
        ta = 0;
        tb = 0;
        for (int i = 0; i < 16; i++) begin
            if (ma[i]) ta = i;
            if (mb[i]) tb = i;
        end
        sh = 0;
        if (ta > 5) begin sa = int'(ma >> (ta - 5)) | 1; sh = sh + ta - 5; end
        else        sa = int'(ma[5:0]);
        if (tb > 5) begin sbb = int'(mb >> (tb - 5)) | 1; sh = sh + tb - 5; end
        else        sbb = int'(mb[5:0]);
        mag = 32'(sa * sbb) << sh;
        res = s ? ~mag : mag;
        tr  = (ta > 5) || (tb > 5);
        return {tr, res};
    endfunction

    // Scoreboard: push on accepted operands, pop and compare on delivered results.
    always @(negedge clk) begin
        exp_t        e;
        logic [32:0] m;
        if (rst) begin
            scb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                assert (scb.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_unexpected observed tag=%0d r=%h expected no result", bus.out_tag, bus.out_r);
                end
                if (scb.size() != 0) begin
                    e = scb.pop_front();
                    checks++;
                    assert (bus.out_r === e.r) else begin
                        errors++;
                        $error("FAIL sb_r tag=%0d observed %h expected %h", e.tag, bus.out_r, e.r);
                    end
                    checks++;
                    assert (bus.out_tag === e.tag) else begin
                        errors++;
                        $error("FAIL sb_tag observed %0d expected %0d", bus.out_tag, e.tag);
                    end
                    checks++;
                    assert (bus.out_trunc === e.trunc) else begin
                        errors++;
                        $error("FAIL sb_trunc tag=%0d observed %b expected %b", e.tag, bus.out_trunc, e.trunc);
                    end
                    if (check_lat) begin
                        checks++;
                        assert (cyc === e.acc + 2) else begin
                            errors++;
                            $error("FAIL sb_latency tag=%0d observed edge %0d expected edge %0d", e.tag, cyc, e.acc + 2);
                        end
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                m       = ref_model(bus.in_a, bus.in_b, bus.in_signed, bus.in_exact);
                e.r     = m[31:0];
                e.trunc = m[32];
                e.tag   = bus.in_tag;
                e.acc   = cyc + 1;
                scb.push_back(e);
            end
        end
    end

    // Offer one operation (called just after a rising edge); returns after acceptance.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sg,
                        input logic ex, input logic [3:0] tg);
        int   n;
        logic rdy;
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_signed = sg;
        bus.in_exact  = ex;
        bus.in_tag    = tg;
        n   = 0;
        rdy = 1'b0;
        do begin
            @(negedge clk);
            rdy = bus.in_ready;
            n++;
            @(posedge clk);
            #1;
        end while (!rdy && n < 50);
        checks++;
        assert (rdy === 1'b1) else begin
            errors++;
            $error("FAIL send_accept tag=%0d observed in_ready=%b expected 1", tg, rdy);
        end
        bus.in_valid = 1'b0;
    endtask

    // Single operation checked against a hand-computed constant.
    task automatic directed(input string nm, input logic [15:0] a, input logic [15:0] b,
                            input logic sg, input logic ex, input logic [3:0] tg,
                            input logic [31:0] exp_r, input logic exp_t);
        int n;
        send(a, b, sg, ex, tg);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 10);
        checks++;
        assert (bus.out_valid === 1'b1) else begin
            errors++;
            $error("FAIL %s_valid observed %b expected 1", nm, bus.out_valid);
        end
        checks++;
        assert (bus.out_r === exp_r) else begin
            errors++;
            $error("FAIL %s_r observed %h expected %h", nm, bus.out_r, exp_r);
        end
        checks++;
        assert (bus.out_trunc === exp_t) else begin
            errors++;
            $error("FAIL %s_trunc observed %b expected %b", nm, bus.out_trunc, exp_t);
        end
        @(posedge clk);
        #1;
    endtask

    // Wait for the scoreboard to empty, then check op_count.
    task automatic drain(input string nm, input logic [15:0] exp_cnt);
        int n;
        n = 0;
        while (scb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        assert (scb.size() === 0) else begin
            errors++;
            $error("FAIL %s_drain observed %0d pending expected 0", nm, scb.size());
        end
        checks++;
        assert (bus.op_count === exp_cnt) else begin
            errors++;
            $error("FAIL %s_op_count observed %0d expected %0d", nm, bus.op_count, exp_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    // One-cycle reset pulse, then verify the pipe came back empty.
    task automatic rst_pulse(input string nm);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        assert (bus.out_valid === 1'b0) else begin
            errors++;
            $error("FAIL %s_out_valid observed %b expected 0", nm, bus.out_valid);
        end
        checks++;
        assert (bus.op_count === 16'd0) else begin
            errors++;
            $error("FAIL %s_op_count observed %0d expected 0", nm, bus.op_count);
        end
        @(posedge clk);
        #1;
    endtask

    logic [15:0] bp_a [5];
    logic [15:0] bp_b [5];
    logic [1:0]  bp_m [5];
    logic [31:0] held;
    int          bp_acc;

    initial begin
        errors        = 0;
        checks        = 0;
        check_lat     = 1'b1;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 16'd1000;
        bus.in_b      = 16'd3;
        bus.in_signed = 1'b0;
        bus.in_exact  = 1'b0;
        bus.in_tag    = 4'd15;
        bus.out_ready = 1'b1;

        // Reset state, with an operand offered that must be ignored.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        assert (bus.out_valid === 1'b0) else begin errors++; $error("FAIL rst_out_valid observed %b expected 0", bus.out_valid); end
        checks++;
        assert (bus.op_count === 16'd0) else begin errors++; $error("FAIL rst_op_count observed %0d expected 0", bus.op_count); end
        checks++;
        assert (bus.out_r === 32'd0) else begin errors++; $error("FAIL rst_out_r observed %h expected 0", bus.out_r); end
        checks++;
        assert (bus.in_ready === 1'b1) else begin errors++; $error("FAIL rst_in_ready observed %b expected 1", bus.in_ready); end
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;

        // Directed products.
        directed("u_apx_1000x3", 16'd1000, 16'd3, 1'b0, 1'b0, 4'd1, 32'd3024, 1'b1);
        directed("u_apx_20x30", 16'd20, 16'd30, 1'b0, 1'b0, 4'd2, 32'd600, 1'b0);
        directed("s_apx_m3x7", 16'hFFFD, 16'd7, 1'b1, 1'b0, 4'd3, 32'hFFFFFFF1, 1'b0);
        directed("s_apx_m1x5", 16'hFFFF, 16'd5, 1'b1, 1'b0, 4'd4, 32'hFFFFFFFF, 1'b0);
        directed("s_ex_m3x7", 16'hFFFD, 16'd7, 1'b1, 1'b1, 4'd5, 32'hFFFFFFEB, 1'b0);
        directed("u_ex_max", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 4'd6, 32'hFFFE0001, 1'b0);
        drain("directed", 16'd6);

        // Streaming: 10 back-to-back mixed-mode ops.
        rst_pulse("pre_stream");
        for (int i = 0; i < 10; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'(i));
        end
        drain("stream", 16'd10);

        // Backpressure: sink stalled while 5 ops are offered.
        check_lat = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bp_a[i] = 16'($urandom);
            bp_b[i] = 16'($urandom);
            bp_m[i] = 2'($urandom_range(0, 3));
        end
        held          = '0;
        bp_acc        = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 40 && bp_acc < 5; c++) begin
            bus.in_valid  = 1'b1;
            bus.in_a      = bp_a[bp_acc];
            bus.in_b      = bp_b[bp_acc];
            bus.in_signed = bp_m[bp_acc][0];
            bus.in_exact  = bp_m[bp_acc][1];
            bus.in_tag    = 4'(bp_acc);
            @(negedge clk);
            if (c == 3) held = bus.out_r;
            if (c == 6) begin
                checks++;
                assert (bp_acc === 3) else begin errors++; $error("FAIL bp_accepted observed %0d expected 3", bp_acc); end
                checks++;
                assert (bus.in_ready === 1'b0) else begin errors++; $error("FAIL bp_in_ready observed %b expected 0", bus.in_ready); end
                checks++;
                assert (bus.out_valid === 1'b1) else begin errors++; $error("FAIL bp_out_valid observed %b expected 1", bus.out_valid); end
                checks++;
                assert (bus.out_r === held) else begin errors++; $error("FAIL bp_hold observed %h expected %h", bus.out_r, held); end
            end
            if (bus.in_ready) bp_acc++;
            @(posedge clk);
            #1;
            if (c == 6) bus.out_ready = 1'b1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        assert (bp_acc === 5) else begin errors++; $error("FAIL bp_all_accepted observed %0d expected 5", bp_acc); end
        drain("bp", 16'd15);
        check_lat = 1'b1;

        // Reset with three operations in flight.
        send(16'd1234, 16'd77, 1'b0, 1'b0, 4'd7);
        send(16'hF00F, 16'd5, 1'b1, 1'b1, 4'd8);
        send(16'd99, 16'd101, 1'b0, 1'b1, 4'd9);
        rst_pulse("mid_rst");
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            assert (bus.out_valid === 1'b0) else begin errors++; $error("FAIL stale_result cycle=%0d observed out_valid=%b expected 0", c, bus.out_valid); end
            @(posedge clk);
            #1;
        end

        // Saturation: 65540 handshakes.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            bus.in_a      = 16'(i);
            bus.in_b      = 16'(i * 7 + 3);
            bus.in_signed = i[0];
            bus.in_exact  = i[1];
            bus.in_tag    = 4'(i);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        drain("saturate", 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/drum_pipe.md
# drum_pipe

Pipelined, parametrised successor to the combinational DRUM approximate multiplier. It accepts one operand pair per cycle over a valid/ready handshake and runs it through three register stages: conditioning/leading-one detection, multiply, then shift/sign. Each operation selects signed or unsigned, and approximate (DRUM-K) or exact. It sits between the operand source and result sink of the datapath and supports full backpressure.

## Interface
- N, 16: width of operand A (N ≥ K)
- M, 16: width of operand B (M ≥ K)
- K, 6: DRUM kept-segment width (3 ≤ K ≤ min(N,M))
- TAG_W, 4: width of the sideband tag carried with each operation
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous and active-high
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept this cycle
- in_a  in  N  operand A
- in_b  in  M  operand B
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned
- in_exact  in  1  1 = exact product, 0 = DRUM approximation
- in_tag  in  TAG_W  passed through unchanged with the result
- out_valid  out  1  result present
- out_ready  in  1  sink accepts result
- out_r  out  N+M  product
- out_tag  out  TAG_W  tag of this result
- out_trunc  out  1  approximate mode and at least one operand was truncated
- op_count  out  16  completed output handshakes, saturating

## Operation
- Handshakes:
  - Input handshake: in_valid & in_ready.
  - Output handshake: out_valid & out_ready.
- Approximate path, unsigned mode:
  - Magnitudes: a' = in_a, b' = in_b.
- Approximate path, signed mode:
  - a' = in_a[N-1] ? ~in_a : in_a, and likewise for b' (one's-complement magnitude).
  - Result sign s = in_a[N-1] ^ in_b[M-1]. In unsigned mode s = 0.
- Per operand (shown for a'):
  - t = index of the leading one. If a' = 0, t = 0.
  - If t > K-1: seg = {1, a'[t-1 : t-K+2], 1}, which is K bits, and shift p = t-K+1.
  - Otherwise: seg = a'[K-1:0] and p = 0.
- Result:
  - r_mag = (segA × segB) << (pA + pB), formed at N+M bits.
  - out_r = s ? ~r_mag : r_mag.
  - out_trunc = (tA > K-1) | (tB > K-1).
- Exact path:
  - out_r is the full N+M-bit product: signed × signed when in_signed = 1, unsigned otherwise.
  - out_trunc = 0.
- Pipeline:
  - S1 registers the conditioned segments, shifts, sign, mode and tag.
  - S2 registers the K×K product. The exact-mode N×M product is also registered at S2.
  - S3 registers the final out_r, out_tag and out_trunc.
  - Each stage has its own valid bit.
- Stall:
  - Global advance enable: en = ~out_valid | out_ready.
  - in_ready = en. There is no bubble compression.
  - When en = 0, all stage registers hold.
- op_count increments on each output handshake and saturates at 0xFFFF.

## Timing
- Latency: an operation accepted at edge E drives out_valid = 1 from edge E+2, provided out_ready stayed high.
- Throughput: one operation per cycle while out_ready = 1.
- out_r, out_tag and out_trunc stay stable while out_valid = 1 and out_ready = 0.
- Simultaneous input and output handshakes in the same cycle are legal. Both complete, and the pipeline shifts by one.
- Reset:
  - While rst = 1, all stage valids, out_valid, out_r, out_tag, out_trunc and op_count are 0.
  - in_ready is 1 while rst = 1, but inputs are ignored.
  - Reset mid-operation discards every in-flight operation. No result from before reset appears afterwards.
- Mode bits and tag are captured per operation, so mixed modes back-to-back are allowed.

## Test plan
All scenarios use the defaults N = M = 16, K = 6, unless stated otherwise.
- Unsigned approximate, a = 1000, b = 3 -> out_r = 3024, out_trunc = 1. Unsigned approximate, a = 20, b = 30 -> out_r = 600, out_trunc = 0.
- Signed approximate:
  - a = 0xFFFD, b = 7 -> out_r = 0xFFFFFFF1.
  - a = 0xFFFF, b = 5 -> out_r = 0xFFFFFFFF.
- Signed exact, a = 0xFFFD, b = 7 -> out_r = 0xFFFFFFEB, out_trunc = 0. Unsigned exact, a = 0xFFFF, b = 0xFFFF -> out_r = 0xFFFE0001.
- Streaming:
  - Setup: out_ready = 1; issue 10 back-to-back operations with tags 0..9 and random modes.
  - Required: results appear on consecutive cycles starting at edge 2 after the first acceptance, in tag order, matching a reference model.
  - Required: op_count = 10 afterwards.
- Backpressure:
  - Setup: out_ready = 0; offer 5 operations.
  - Required: exactly 3 are accepted (edges 0, 1, 2), then in_ready = 0 with out_r held.
  - Then raise out_ready: all 5 operations complete in order, with none lost or duplicated.
- Reset:
  - Setup: assert rst for 1 cycle with 3 operations in flight.
  - Required: out_valid = 0, op_count = 0, and no stale result afterwards.
  - Separately, drive 65 540 handshakes: op_count stays at 0xFFFF.
